// File: rtl/div16_seq_ctrl_if.sv
// Interface: div16_seq_ctrl_if
// Purpose : Bundles the divide handshake and the shared adder/XOR16_1 datapath
//           hookup used by div16_seq_ctrl.
// Signals : start, n, d        - divide request and operands (core -> sequencer)
//           add_a, xor_a, xor_b - drive the shared adder / conditional inverter
//           sum, cout           - adder results fed back to the sequencer
//           busy, done, q, r, dz - status and results (sequencer -> core)
// Modports: master - core side, including the shared adder that returns sum/cout
//           slave  - the divide sequencer
interface div16_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] xor_a;
  logic             xor_b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dz;

  modport master (
    output start, n, d, sum, cout,
    input  add_a, xor_a, xor_b, busy, done, q, r, dz
  );

  modport slave (
    input  start, n, d, sum, cout,
    output add_a, xor_a, xor_b, busy, done, q, r, dz
  );
endinterface

// File: rtl/div16_seq_ctrl.sv
// Module : div16_seq_ctrl
// Purpose: Multi-cycle unsigned 16-bit restoring divider. It borrows the ALU's
//          adder and XOR16_1 conditional inverter for one trial subtract per
//          cycle and returns quotient/remainder through a start/busy/done
//          handshake. A divide takes 16 RUN cycles plus one FIN cycle.
// Ports  : clk - rising-edge clock
//          rst - synchronous, active-high reset; aborts any divide in progress
//          bus - div16_seq_ctrl_if.slave (start/n/d in, add_a/xor_a/xor_b out,
//                sum/cout in, busy/done/q/r/dz out)
module div16_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  div16_seq_ctrl_if.slave      bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] dvd;   // dividend, shifted left one bit per iteration
  logic [WIDTH-1:0] dvs;   // divisor held for the whole divide
  logic [WIDTH-1:0] pr;    // partial remainder
  logic [WIDTH-1:0] quo;   // quotient bits collected MSB first
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dz;

  logic [WIDTH:0]   s;        // shifted-in trial value {pr, next dividend bit}
  logic             ok;       // trial subtract succeeded
  logic [WIDTH-1:0] pr_next;
  logic [WIDTH-1:0] quo_next;
  logic             run;

  assign run = (state == RUN);

  // NOTE: every variable assigned in an always_comb gets a default at the top,
  // so no path through the block can leave it holding and infer a latch.
  always_comb begin
    s        = {pr, dvd[WIDTH-1]};
    // When s[WIDTH] is set, s is at least 2^16 and exceeds any divisor, so the
    // subtract succeeds and the wrapped 16-bit sum is the exact new remainder.
    ok       = bus.cout | s[WIDTH];
    pr_next  = ok ? bus.sum : s[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ok};
  end

  // Outside RUN the shared adder sees a plain add of zero, so the inverter is
  // never left in subtract mode for the rest of the ALU.
  assign bus.add_a = run ? s[WIDTH-1:0] : '0;
  assign bus.xor_a = run ? dvs : '0;
  assign bus.xor_b = run;

  assign bus.busy  = run;
  assign bus.done  = (state == FIN);   // FIN always lasts exactly one cycle
  assign bus.q     = q;
  assign bus.r     = r;
  assign bus.dz    = dz;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      pr    <= '0;
      quo   <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (bus.start) begin
            state <= RUN;
            dvd   <= bus.n;
            dvs   <= bus.d;
            pr    <= '0;
            quo   <= '0;
            cnt   <= '0;
            dz    <= (bus.d == '0);
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          pr  <= pr_next;
          quo <= quo_next;
          dvd <= dvd << 1;
          cnt <= cnt + CNT_W'(1);
          // Results are published only on the completing edge; q/r keep the
          // previous divide's values while this one is in flight.
          if (cnt == LAST) begin
            state <= FIN;
            q     <= quo_next;
            r     <= pr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div16_seq_ctrl.sv
// Testbench: tb_div16_seq_ctrl
// Purpose  : Drives div16_seq_ctrl through directed and random divides, models
//            the shared adder + XOR16_1 inverter, and compares every result
//            against plain integer division.
module tb_div16_seq_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  div16_seq_ctrl_if #(.WIDTH(16)) bus ();

  div16_seq_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared datapath: XOR16_1 conditionally inverts xor_a, xor_b is carry-in.
  assign {bus.cout, bus.sum} = {1'b0, bus.add_a}
                             + {1'b0, bus.xor_a ^ {16{bus.xor_b}}}
                             + {16'd0, bus.xor_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: unsigned division, with a zero divisor giving all-ones / n.
  function automatic void ref_div(input logic [15:0] nv, input logic [15:0] dv,
                                  output logic [15:0] qe, output logic [15:0] re);
    if (dv == 16'd0) begin
      qe = 16'hFFFF;
      re = nv;
    end else begin
      qe = nv / dv;
      re = nv % dv;
    end
  endfunction

  // Issues one START pulse and waits for DONE. lat counts falling edges after
  // the accept edge's falling edge until DONE is seen (16 expected).
  task automatic do_div(input logic [15:0] nv, input logic [15:0] dv,
                        output int lat, output int busy_cyc,
                        output logic q_moved);
    logic [15:0] q0;
    q0 = bus.q;
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = nv;
    bus.d     = dv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.n     = 16'($urandom);   // operands must already be captured
    bus.d     = 16'($urandom);
    lat      = 0;
    busy_cyc = 0;
    q_moved  = 1'b0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.q !== q0) q_moved = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.n     = 16'd501;
    bus.d     = 16'd7;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.q !== 16'd0) begin errors++; $display("FAIL reset_q: got %h expected 0000", bus.q); end
    checks++; if (bus.r !== 16'd0) begin errors++; $display("FAIL reset_r: got %h expected 0000", bus.r); end
    checks++; if (bus.dz !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", bus.dz); end
    checks++; if (bus.add_a !== 16'd0 || bus.xor_a !== 16'd0 || bus.xor_b !== 1'b0) begin
      errors++; $display("FAIL reset_datapath: got add_a=%h xor_a=%h xor_b=%b expected all 0", bus.add_a, bus.xor_a, bus.xor_b);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, busy_cyc;
    logic q_moved;
    do_div(16'd501, 16'd7, lat, busy_cyc, q_moved);
    checks++; if (lat !== 16) begin errors++; $display("FAIL basic_latency: got %0d expected 16", lat); end
    checks++; if (busy_cyc !== 16) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 16", busy_cyc); end
    checks++; if (q_moved !== 1'b0) begin errors++; $display("FAIL basic_q_early: got q change while busy, expected none"); end
    checks++; if (bus.q !== 16'd71) begin errors++; $display("FAIL basic_q: got %0d expected 71", bus.q); end
    checks++; if (bus.r !== 16'd4) begin errors++; $display("FAIL basic_r: got %0d expected 4", bus.r); end
    checks++; if (bus.dz !== 1'b0) begin errors++; $display("FAIL basic_dz: got %b expected 0", bus.dz); end
    checks++; if (bus.busy !== 1'b0 || bus.xor_b !== 1'b0) begin
      errors++; $display("FAIL basic_fin_idle: got busy=%b xor_b=%b expected 0 0", bus.busy, bus.xor_b);
    end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", bus.done); end
    checks++; if (bus.q !== 16'd71 || bus.r !== 16'd4) begin
      errors++; $display("FAIL basic_hold: got q=%0d r=%0d expected 71 4", bus.q, bus.r);
    end
  endtask

  task automatic test_corners();
    logic [15:0] nv [4];
    logic [15:0] dv [4];
    logic [15:0] qe [4];
    logic [15:0] re [4];
    int lat, busy_cyc;
    logic q_moved;
    nv[0] = 16'hFFFF; dv[0] = 16'h0001; qe[0] = 16'hFFFF; re[0] = 16'h0000;
    nv[1] = 16'h0003; dv[1] = 16'hFFFF; qe[1] = 16'h0000; re[1] = 16'h0003;
    nv[2] = 16'hFFFF; dv[2] = 16'h8000; qe[2] = 16'h0001; re[2] = 16'h7FFF;
    nv[3] = 16'hFFFE; dv[3] = 16'hFFFF; qe[3] = 16'h0000; re[3] = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      do_div(nv[i], dv[i], lat, busy_cyc, q_moved);
      checks++; if (lat !== 16) begin errors++; $display("FAIL corner%0d_latency: got %0d expected 16", i, lat); end
      checks++; if (bus.q !== qe[i] || bus.r !== re[i]) begin
        errors++; $display("FAIL corner%0d_result: %h/%h got q=%h r=%h expected q=%h r=%h", i, nv[i], dv[i], bus.q, bus.r, qe[i], re[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, busy_cyc;
    logic q_moved;
    do_div(16'd501, 16'd0, lat, busy_cyc, q_moved);
    checks++; if (lat !== 16) begin errors++; $display("FAIL dz_latency: got %0d expected 16", lat); end
    checks++; if (bus.q !== 16'hFFFF) begin errors++; $display("FAIL dz_q: got %h expected ffff", bus.q); end
    checks++; if (bus.r !== 16'd501) begin errors++; $display("FAIL dz_r: got %0d expected 501", bus.r); end
    checks++; if (bus.dz !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", bus.dz); end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 16'd501;
    bus.d     = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (lat == 5) begin
        bus.start = 1'b1;
        bus.n     = 16'd9;
        bus.d     = 16'd2;
      end else if (lat == 6) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 16) begin errors++; $display("FAIL ignore_latency: got %0d expected 16", lat); end
    checks++; if (bus.q !== 16'd71 || bus.r !== 16'd4) begin
      errors++; $display("FAIL ignore_result: got q=%0d r=%0d expected 71 4", bus.q, bus.r);
    end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_not_queued: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_reset_abort();
    int lat, busy_cyc;
    logic q_moved;
    logic [15:0] qe, re;
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 16'd501;
    bus.d     = 16'd0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL abort_status: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    checks++; if (bus.q !== 16'd0 || bus.r !== 16'd0 || bus.dz !== 1'b0) begin
      errors++; $display("FAIL abort_results: got q=%h r=%h dz=%b expected 0 0 0", bus.q, bus.r, bus.dz);
    end
    checks++; if (bus.xor_b !== 1'b0) begin errors++; $display("FAIL abort_xor_b: got %b expected 0", bus.xor_b); end
    repeat (10) @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", bus.done); end
    ref_div(16'd1000, 16'd33, qe, re);
    do_div(16'd1000, 16'd33, lat, busy_cyc, q_moved);
    checks++; if (lat !== 16 || bus.q !== qe || bus.r !== re) begin
      errors++; $display("FAIL abort_restart: got lat=%0d q=%0d r=%0d expected 16 %0d %0d", lat, bus.q, bus.r, qe, re);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 16'd501;
    bus.d     = 16'd7;
    @(negedge clk);
    bus.n = 16'd100;   // start stays high; these are the next divide's operands
    bus.d = 16'd10;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 16) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 16", lat); end
    checks++; if (bus.q !== 16'd71 || bus.r !== 16'd4) begin
      errors++; $display("FAIL b2b_first_result: got q=%0d r=%0d expected 71 4", bus.q, bus.r);
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL b2b_handover: got done=%b busy=%b expected 0 1", bus.done, bus.busy);
    end
    checks++; if (bus.q !== 16'd71) begin errors++; $display("FAIL b2b_q_hold: got %0d expected 71", bus.q); end
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_done_spacing: got %0d expected 17", lat); end
    checks++; if (bus.q !== 16'd10 || bus.r !== 16'd0) begin
      errors++; $display("FAIL b2b_second_result: got q=%0d r=%0d expected 10 0", bus.q, bus.r);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, busy_cyc;
    logic q_moved;
    logic [15:0] nv, dv, qe, re;
    for (int i = 0; i < 24; i++) begin
      nv = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       dv = 16'd0;
        1:       dv = 16'($urandom_range(1, 15));
        2:       dv = 16'($urandom);
        default: dv = 16'd1 << $urandom_range(0, 15);
      endcase
      ref_div(nv, dv, qe, re);
      do_div(nv, dv, lat, busy_cyc, q_moved);
      checks++; if (lat !== 16 || busy_cyc !== 16) begin
        errors++; $display("FAIL rand%0d_timing: got lat=%0d busy=%0d expected 16 16", i, lat, busy_cyc);
      end
      checks++; if (bus.q !== qe || bus.r !== re || bus.dz !== (dv == 16'd0)) begin
        errors++; $display("FAIL rand%0d_result: %h/%h got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                           i, nv, dv, bus.q, bus.r, bus.dz, qe, re, (dv == 16'd0));
      end
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.n     = 16'd0;
    bus.d     = 16'd0;
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
